// File: rtl/conv33_window_sender.sv
// Walks every valid 3x3 window of an IMG_H x IMG_W map, fetches nine taps from a
// synchronous-read buffer, packs them, and offers each window over valid/ready.
module conv33_window_sender #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  valid_out,
    input  logic                  ready_in
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SEND} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [3:0]        LAST_TAP = 4'd8;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   row, col, ky, kx;
    logic [3:0]          tap;
    logic [DATA_W-1:0]   slot [9];
    logic                last_win;
    logic                handshake;

    assign last_win  = (row == LAST_ROW) && (col == LAST_COL);
    assign handshake = (state == SEND) && ready_in;
    assign busy      = (state != IDLE);
    assign valid_out = (state == SEND);
    assign rd_en     = (state == FETCH);
    assign rd_addr   = rd_en ? (row + ky) * W_A + col + kx : '0;

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (tap == LAST_TAP) state_nxt = DRAIN;
            DRAIN:   state_nxt = SEND;
            SEND:    if (ready_in) state_nxt = last_win ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            ky  <= '0;
            kx  <= '0;
            tap <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    row <= '0;
                    col <= '0;
                    ky  <= '0;
                    kx  <= '0;
                    tap <= '0;
                end
                FETCH: begin
                    if (tap == LAST_TAP) begin
                        tap <= '0;
                        kx  <= '0;
                        ky  <= '0;
                    end else begin
                        tap <= tap + 4'd1;
                        if (kx == ADDR_W'(2)) begin
                            kx <= '0;
                            ky <= ky + ADDR_W'(1);
                        end else begin
                            kx <= kx + ADDR_W'(1);
                        end
                    end
                end
                SEND: if (ready_in && !last_win) begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + ADDR_W'(1);
                    end else begin
                        col <= col + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the tap slots are reset because win_data must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) slot[k] <= '0;
        end else if (state == FETCH && tap != 4'd0) begin
            slot[tap - 4'd1] <= rd_data;
        end else if (state == DRAIN) begin
            slot[8] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= handshake && last_win;
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < 9; k++) win_data[k*DATA_W +: DATA_W] = slot[k];
    end

endmodule

// File: doc/conv33_window_sender.md
# conv33_window_sender

Transmit-side controller for the 3x3 convolution input path. On `start` it walks every valid 3x3 window of an IMG_H x IMG_W feature map (stride 1, no padding). For each window it issues nine reads to a synchronous-read feature buffer and packs the nine pixels into one word. It then offers that word over a valid/ready handshake to the downstream window consumer, and pulses `done` after the last window is accepted.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 8, feature-map width in pixels (>= 3)
- IMG_H, 8, feature-map height in pixels (>= 3)
- ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one full map pass; sampled only in IDLE
- done  out  1  one-cycle pulse after last window handshake
- busy  out  1  high in every non-IDLE state
- rd_en  out  1  buffer read enable
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  buffer read data, valid exactly 1 cycle after rd_en
- win_data  out  9*DATA_W  packed window; tap k in bits [k*DATA_W +: DATA_W]
- valid_out  out  1  win_data holds a complete window
- ready_in  in  1  consumer accepts window

## Operation
- Window position (row, col): row 0..IMG_H-3, col 0..IMG_W-3, raster order with col fastest. Total windows = (IMG_H-2)*(IMG_W-2).
- Tap k = ky*3+kx, with ky, kx in 0..2. Tap address = (row+ky)*IMG_W + (col+kx), computed at ADDR_W width with no wrap for legal parameters.
- States:
  - IDLE: start=1 -> FETCH with row=col=tap=0.
  - FETCH: rd_en=1 and rd_addr=address of tap counter for 9 consecutive cycles (taps 0..8). Each cycle, rd_data from the previous cycle's read is written into slot tap-1. After tap 8 -> DRAIN.
  - DRAIN: rd_en=0; capture tap 8 -> SEND.
  - SEND: valid_out=1; win_data held stable. On valid_out & ready_in (handshake):
    - if last window (row=IMG_H-3, col=IMG_W-3): -> IDLE, done<=1.
    - else advance col, wrapping to 0 and incrementing row at IMG_W-3 -> FETCH.
- done: registered; high exactly one cycle, the first IDLE cycle after the final handshake. start in that same cycle is accepted.
- start outside IDLE is ignored. ready_in without valid_out has no effect.
- rd_en is low in IDLE, DRAIN and SEND. No read is issued while stalled.
- Reset (any time, including mid-pass): state IDLE, row/col/tap 0, done 0, busy 0, rd_en 0, rd_addr 0, valid_out 0, win_data 0. A partially built window is discarded.

## Timing
- Start accepted at cycle 0. FETCH runs cycles 1-9, DRAIN at 10, valid_out rises at 11.
- With ready_in held high, the window period is 11 cycles: handshake n occurs at cycle 11*(n+1).
- Default 8x8 map has 36 windows: last handshake at cycle 396, done at 397.
- Read latency is fixed at 1 cycle; rd_data is sampled the cycle after the matching rd_en.
- Backpressure: valid_out, win_data and internal counters hold indefinitely while ready_in=0.
- valid_out drops the cycle after a handshake. It is never high in FETCH or DRAIN.

## Test plan
- Default params, mem[a]=a, ready_in=1:
  - window 0 taps = 0,1,2,8,9,10,16,17,18;
  - window 1 taps = 1,2,3,9,10,11,17,18,19;
  - window 35 taps = 45,46,47,53,54,55,61,62,63;
  - exactly 36 handshakes; done high only at cycle 397.
- Backpressure: hold ready_in=0 for 5 cycles after valid_out rises on window 0. Required: valid_out stays 1, win_data unchanged, rd_en=0. Release -> handshake, then FETCH on the next cycle.
- Row wrap: accept window 5 (row 0, col 5). The next fetch uses tap-0 address 8 (row 1, col 0).
- start pulsed during FETCH and during SEND: no restart, window sequence and count unchanged. start in the done cycle: new pass begins, rd_en high the following cycle at address 0.
- Reset asserted mid-FETCH of window 3: all outputs 0 immediately. After release, a new start produces window 0 = 0,1,2,8,9,10,16,17,18.
- IMG_W=IMG_H=3: exactly one window, taps 0..8; done at cycle 12.
